// File: rtl/accumulator_pkg.sv
// Shared helpers for the multi-channel accumulator: channel-index sizing and
// the signed saturation limits of an accumulator of a given width.
package accumulator_pkg;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic longint acc_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint acc_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/accumulator_sat_add.sv
// Combinational accumulate step: widened signed add, overflow detect, and
// clamp-or-wrap of the result back to the accumulator width.
module accumulator_sat_add
  import accumulator_pkg::*;
#(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_ACC_WIDTH  = 16,
  parameter int p_SATURATE   = 1
) (
  input  logic signed [p_ACC_WIDTH-1:0]  acc_i,
  input  logic signed [p_DATA_WIDTH-1:0] summand_i,
  output logic signed [p_ACC_WIDTH-1:0]  result_o,
  output logic                           overflow_o
);

  localparam int SW = p_ACC_WIDTH + 1;
  localparam logic signed [p_ACC_WIDTH-1:0] SAT_MAX = p_ACC_WIDTH'(acc_max(p_ACC_WIDTH));
  localparam logic signed [p_ACC_WIDTH-1:0] SAT_MIN = p_ACC_WIDTH'(acc_min(p_ACC_WIDTH));

  logic [SW-1:0] sum;
  logic          ovf;

  // One guard bit is enough since the summand is never wider than the accumulator.
  always_comb begin
    sum = {acc_i[p_ACC_WIDTH-1], acc_i}
        + {{(SW - p_DATA_WIDTH){summand_i[p_DATA_WIDTH-1]}}, summand_i};
    ovf = sum[SW-1] ^ sum[SW-2];
    result_o = sum[p_ACC_WIDTH-1:0];
    if (ovf && (p_SATURATE != 0)) result_o = sum[SW-1] ? SAT_MIN : SAT_MAX;
  end

  assign overflow_o = ovf;

endmodule

// File: rtl/multi_channel_accumulator.sv
// Bank of independent signed accumulators with sticky overflow flags and a
// read-and-clear dump path that returns the result one cycle later.
module multi_channel_accumulator
  import accumulator_pkg::*;
#(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_ACC_WIDTH  = 16,
  parameter int p_CHANNELS   = 4,
  parameter int p_SATURATE   = 1,
  localparam int CH_W        = ch_idx_w(p_CHANNELS)
) (
  input  logic                           i_CLK,
  input  logic                           i_RESET,
  input  logic                           i_CLK_EN,
  input  logic                           i_VALID,
  input  logic [CH_W-1:0]                i_CHANNEL,
  input  logic signed [p_DATA_WIDTH-1:0] i_SUMMAND,
  input  logic                           i_DUMP,
  output logic                           o_VALID,
  output logic [CH_W-1:0]                o_CHANNEL,
  output logic signed [p_ACC_WIDTH-1:0]  o_ACCUMULATION,
  output logic                           o_OVERFLOW
);

  logic [p_CHANNELS-1:0][p_ACC_WIDTH-1:0] acc_q, acc_d;
  logic [p_CHANNELS-1:0]                  sticky_q, sticky_d;
  logic                                   vld_q, vld_d;
  logic [CH_W-1:0]                        ch_q, ch_d;
  logic signed [p_ACC_WIDTH-1:0]          accum_q, accum_d;
  logic                                   ovf_q, ovf_d;

  logic                          in_range, accept, beat_ovf;
  logic signed [p_ACC_WIDTH-1:0] cur_acc, result;

  assign in_range = int'(i_CHANNEL) < p_CHANNELS;
  assign accept   = i_CLK_EN & i_VALID & in_range;
  assign cur_acc  = in_range ? acc_q[i_CHANNEL] : '0;

  accumulator_sat_add #(
    .p_DATA_WIDTH (p_DATA_WIDTH),
    .p_ACC_WIDTH  (p_ACC_WIDTH),
    .p_SATURATE   (p_SATURATE)
  ) u_add (
    .acc_i      (cur_acc),
    .summand_i  (i_SUMMAND),
    .result_o   (result),
    .overflow_o (beat_ovf)
  );

  // Output fields hold between pulses; only the valid strobe self-clears.
  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    vld_d    = 1'b0;
    ch_d     = ch_q;
    accum_d  = accum_q;
    ovf_d    = ovf_q;
    if (accept) begin
      if (i_DUMP) begin
        acc_d[i_CHANNEL]    = '0;
        sticky_d[i_CHANNEL] = 1'b0;
        vld_d               = 1'b1;
        ch_d                = i_CHANNEL;
        accum_d             = result;
        ovf_d               = sticky_q[i_CHANNEL] | beat_ovf;
      end else begin
        acc_d[i_CHANNEL]    = result;
        sticky_d[i_CHANNEL] = sticky_q[i_CHANNEL] | beat_ovf;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      acc_q    <= '0;
      sticky_q <= '0;
      vld_q    <= 1'b0;
      ch_q     <= '0;
      accum_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      vld_q    <= vld_d;
      ch_q     <= ch_d;
      accum_q  <= accum_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_VALID        = vld_q;
  assign o_CHANNEL      = ch_q;
  assign o_ACCUMULATION = accum_q;
  assign o_OVERFLOW     = ovf_q;

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Drives a saturating and a wrapping instance with the same beats and checks
// both against an integer-arithmetic reference model every cycle.
module tb_multi_channel_accumulator;

  logic              i_CLK = 1'b0;
  logic              i_RESET = 1'b0;
  logic              i_CLK_EN = 1'b0;
  logic              i_VALID = 1'b0;
  logic [1:0]        i_CHANNEL = '0;
  logic signed [7:0] i_SUMMAND = '0;
  logic              i_DUMP = 1'b0;

  logic              v_s, v_w, ov_s, ov_w;
  logic [1:0]        ch_s, ch_w;
  logic signed [9:0] acc_s, acc_w;

  int n_chk = 0;
  int n_pass = 0;

  // Model state: index 0 = saturating instance, 1 = wrapping instance.
  int macc[2][4];
  bit mst[2][4];
  int eacc[2];
  bit eovf[2];
  int ech[2];
  bit evld;

  always #5 i_CLK = ~i_CLK;

  multi_channel_accumulator #(
    .p_DATA_WIDTH(8), .p_ACC_WIDTH(10), .p_CHANNELS(4), .p_SATURATE(1)
  ) dut_s (
    .i_CLK(i_CLK), .i_RESET(i_RESET), .i_CLK_EN(i_CLK_EN), .i_VALID(i_VALID),
    .i_CHANNEL(i_CHANNEL), .i_SUMMAND(i_SUMMAND), .i_DUMP(i_DUMP),
    .o_VALID(v_s), .o_CHANNEL(ch_s), .o_ACCUMULATION(acc_s), .o_OVERFLOW(ov_s)
  );

  multi_channel_accumulator #(
    .p_DATA_WIDTH(8), .p_ACC_WIDTH(10), .p_CHANNELS(4), .p_SATURATE(0)
  ) dut_w (
    .i_CLK(i_CLK), .i_RESET(i_RESET), .i_CLK_EN(i_CLK_EN), .i_VALID(i_VALID),
    .i_CHANNEL(i_CHANNEL), .i_SUMMAND(i_SUMMAND), .i_DUMP(i_DUMP),
    .o_VALID(v_w), .o_CHANNEL(ch_w), .o_ACCUMULATION(acc_w), .o_OVERFLOW(ov_w)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model(input bit rst, input bit en, input bit vld, input int ch,
                       input int s, input bit dmp);
    evld = 1'b0;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) begin macc[k][c] = 0; mst[k][c] = 1'b0; end
        eacc[k] = 0; eovf[k] = 1'b0; ech[k] = 0;
      end
    end else if (en && vld && ch < 4) begin
      for (int k = 0; k < 2; k++) begin
        int sum, res;
        bit ov;
        sum = macc[k][ch] + s;
        ov  = (sum > 511) || (sum < -512);
        if (!ov)         res = sum;
        else if (k == 0) res = (sum > 511) ? 511 : -512;
        else             res = (sum > 511) ? sum - 1024 : sum + 1024;
        if (dmp) begin
          eacc[k] = res; eovf[k] = mst[k][ch] | ov; ech[k] = ch;
          macc[k][ch] = 0; mst[k][ch] = 1'b0;
          evld = 1'b1;
        end else begin
          macc[k][ch] = res; mst[k][ch] = mst[k][ch] | ov;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_vld_s"}, v_s, evld);
    chk({tag, "_ch_s"}, ch_s, ech[0]);
    chk({tag, "_acc_s"}, acc_s, eacc[0]);
    chk({tag, "_ovf_s"}, ov_s, eovf[0]);
    chk({tag, "_vld_w"}, v_w, evld);
    chk({tag, "_ch_w"}, ch_w, ech[1]);
    chk({tag, "_acc_w"}, acc_w, eacc[1]);
    chk({tag, "_ovf_w"}, ov_w, eovf[1]);
  endtask

  task automatic beat(input string tag, input bit en, input bit vld, input int ch,
                      input int s, input bit dmp);
    @(negedge i_CLK);
    i_RESET = 1'b0; i_CLK_EN = en; i_VALID = vld;
    i_CHANNEL = 2'(ch); i_SUMMAND = 8'(s); i_DUMP = dmp;
    @(posedge i_CLK);
    #1;
    model(1'b0, en, vld, ch, s, dmp);
    check_all(tag);
  endtask

  // Reset is applied with an otherwise valid dump beat to exercise its priority.
  task automatic do_reset(input string tag);
    @(negedge i_CLK);
    i_RESET = 1'b1; i_CLK_EN = 1'b1; i_VALID = 1'b1; i_DUMP = 1'b1;
    i_CHANNEL = 2'($urandom_range(0, 3)); i_SUMMAND = 8'($urandom_range(0, 255));
    @(posedge i_CLK);
    #1;
    model(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    check_all(tag);
  endtask

  initial begin
    do_reset("rst0");

    for (int i = 0; i < 4; i++) beat("c2add", 1, 1, 2, 100, 0);
    chk("c2add_novld", v_s, 0);
    beat("c2dump", 1, 1, 2, 100, 1);
    chk("c2dump_acc", acc_s, 500);
    chk("c2dump_ch", ch_s, 2);
    beat("c2clr", 1, 1, 2, 0, 1);
    chk("c2clr_acc", acc_s, 0);

    for (int i = 0; i < 5; i++) beat("c1pos", 1, 1, 1, 127, 0);
    beat("c1pdump", 1, 1, 1, 0, 1);
    chk("c1pos_sat", acc_s, 511);
    chk("c1pos_ovf", ov_s, 1);
    for (int i = 0; i < 5; i++) beat("c1neg", 1, 1, 1, -128, 0);
    beat("c1ndump", 1, 1, 1, 0, 1);
    chk("c1neg_sat", acc_s, -512);
    beat("c1clr", 1, 1, 1, 0, 1);
    chk("c1clr_ovf", ov_s, 0);

    for (int i = 0; i < 4; i++) beat("c0fill", 1, 1, 0, 127, 0);
    beat("c0fill", 1, 1, 0, 3, 0);
    beat("c0wrap", 1, 1, 0, 1, 1);
    chk("c0wrap_acc", acc_w, -512);
    chk("c0wrap_ovf", ov_w, 1);

    beat("ilv", 1, 1, 0, 5, 0);
    beat("ilv", 1, 1, 3, -7, 0);
    beat("ilv", 1, 1, 0, 5, 0);
    beat("ilv", 1, 1, 3, -7, 0);
    beat("ilvd0", 1, 1, 0, 0, 1);
    chk("ilvd0_acc", acc_s, 10);
    beat("ilvd3", 1, 1, 3, 0, 1);
    chk("ilvd3_acc", acc_s, -14);
    chk("ilvd3_vld", v_s, 1);

    beat("c2en", 1, 1, 2, 50, 0);
    beat("c2frz", 0, 1, 2, 50, 0);
    beat("c2frz", 0, 1, 2, 50, 1);
    beat("c2frz", 0, 1, 2, 50, 0);
    do_reset("rst1");
    beat("c2post", 1, 1, 2, 3, 1);
    chk("c2post_acc", acc_s, 3);
    chk("c2post_ovf", ov_s, 0);

    beat("c1m3", 1, 1, 1, -3, 0);
    beat("c1m3d", 1, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) beat("hold", 1, 1, $urandom_range(0, 3), 11, 0);
    chk("hold_acc", acc_s, -3);
    chk("hold_vld", v_s, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset("rrst");
      else beat("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 3), int'($urandom_range(0, 255)) - 128,
                $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
